// File: rtl/trigger_cond_pkg.sv
// Shared types and default widths for the trigger conditioner front-end.
package trigger_cond_pkg;

    localparam int unsigned DELAY_W_DEF = 8;
    localparam int unsigned CNT_W_DEF   = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FIRE    = 2'd1,
        WAIT_LO = 2'd2,
        WAIT_HI = 2'd3
    } trig_state_e;

endpackage

// File: rtl/trig_debounce.sv
// Two-flop synchroniser followed by a counter-based debouncer; level_out
// changes only after DEBOUNCE_CYCLES consecutive samples disagree with it.
module trig_debounce
    import trigger_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic level_out
);

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= raw_in;
            sync_q2 <= sync_q1;
        end
    end

    // Any sample agreeing with the current level restarts the stability count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            level_out <= 1'b0;
        end else if (sync_q2 == level_out) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level_out <= sync_q2;
            cnt       <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/trigger_conditioner.sv
// Debounced event -> trigger pulse + latched delay for the delay timer, with
// busy lockout and sticky overrun. Define TRIGGER_COND_AUTO_REPEAT_EN to retrigger while held.
module trigger_conditioner
    import trigger_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = CNT_W_DEF,
    parameter int unsigned TRIG_CYCLES     = 1,
    parameter int unsigned DELAY_W         = DELAY_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               button_in,
    input  logic [DELAY_W-1:0] delay_sel,
    input  logic               timer_done,
    input  logic               overrun_clr,
    output logic               trigger,
    output logic [DELAY_W-1:0] delay_value,
    output logic               busy,
    output logic               overrun
);

    localparam int unsigned TRIG_W = (TRIG_CYCLES > 1) ? $clog2(TRIG_CYCLES) : 1;

    logic               level;
    logic               level_q;
    logic               rise;
    trig_state_e        state;
    trig_state_e        state_d;
    logic [TRIG_W-1:0]  fire_cnt;
    logic [TRIG_W-1:0]  fire_cnt_d;
    logic               trigger_d;
    logic               busy_d;
    logic               overrun_d;
    logic [DELAY_W-1:0] delay_d;

    trig_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debounce (
        .clk       (clk),
        .reset     (reset),
        .raw_in    (button_in),
        .level_out (level)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            fire_cnt    <= '0;
            trigger     <= 1'b0;
            delay_value <= '0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_d;
            fire_cnt    <= fire_cnt_d;
            trigger     <= trigger_d;
            delay_value <= delay_d;
            busy        <= busy_d;
            overrun     <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state;
        fire_cnt_d = fire_cnt;
        trigger_d  = trigger;
        delay_d    = delay_value;
        busy_d     = busy;
        overrun_d  = overrun;

        case (state)
            IDLE: begin
                if (rise) begin
                    state_d    = FIRE;
                    trigger_d  = 1'b1;
                    delay_d    = delay_sel;
                    fire_cnt_d = '0;
                end
            end
            FIRE: begin
                if (fire_cnt == TRIG_W'(TRIG_CYCLES - 1)) begin
                    trigger_d = 1'b0;
                    state_d   = WAIT_LO;
                end else begin
                    fire_cnt_d = fire_cnt + TRIG_W'(1);
                end
            end
            // A done level left high by the previous run must drop before completion counts.
            WAIT_LO: begin
                if (!timer_done) begin
                    state_d = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (timer_done) begin
`ifdef TRIGGER_COND_AUTO_REPEAT_EN
                    if (level) begin
                        state_d    = FIRE;
                        trigger_d  = 1'b1;
                        delay_d    = delay_sel;
                        fire_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);

        // Set has priority over clear.
        if (rise && (state != IDLE)) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_trigger_conditioner.sv
// Scoreboard bench for trigger_conditioner: directed plan items plus random traffic.
module tb_trigger_conditioner;

    localparam int unsigned DC = 4;
    localparam int unsigned TC = 2;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          button_in = 1'b0;
    logic [DW-1:0] delay_sel = '0;
    logic          timer_done = 1'b1;
    logic          overrun_clr = 1'b0;
    logic          trigger;
    logic [DW-1:0] delay_value;
    logic          busy;
    logic          overrun;

    int errors = 0;
    int checks = 0;

    trigger_conditioner #(
        .DEBOUNCE_CYCLES (DC),
        .CNT_W           (5),
        .TRIG_CYCLES     (TC),
        .DELAY_W         (DW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .button_in   (button_in),
        .delay_sel   (delay_sel),
        .timer_done  (timer_done),
        .overrun_clr (overrun_clr),
        .trigger     (trigger),
        .delay_value (delay_value),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] delay;
        logic [31:0]   cyc;
    } trig_ev_t;

    trig_ev_t exp_q[$];

    // Reference model state
    int         cyc = 0;
    bit         m_s1, m_s2, m_level, m_level_q;
    bit         hist[$];
    bit         m_busy, m_trig, m_over, m_seen_low;
    int         m_trig_left;
    logic [DW-1:0] m_delay;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endfunction

    function automatic void model_clear();
        m_s1 = 0; m_s2 = 0; m_level = 0; m_level_q = 0;
        hist.delete();
        m_busy = 0; m_trig = 0; m_over = 0; m_seen_low = 0;
        m_trig_left = 0; m_delay = '0;
        exp_q.delete();
    endfunction

    function automatic void model_fire();
        trig_ev_t ev;
        m_trig      = 1;
        m_busy      = 1;
        m_trig_left = TC;
        m_delay     = delay_sel;
        ev.delay    = delay_sel;
        ev.cyc      = 32'(cyc);
        exp_q.push_back(ev);
    endfunction

    function automatic void model_step();
        bit s, rise, lvl_now, differ;
        s       = m_s2;
        lvl_now = m_level;
        rise    = m_level && !m_level_q;

        if (rise && m_busy) m_over = 1;
        else if (overrun_clr) m_over = 0;

        if (!m_busy) begin
            if (rise) model_fire();
        end else if (m_trig_left > 0) begin
            if (m_trig_left == 1) begin
                m_trig     = 0;
                m_seen_low = 0;
            end
            m_trig_left--;
        end else if (!m_seen_low) begin
            if (!timer_done) m_seen_low = 1;
        end else if (timer_done) begin
`ifdef TRIGGER_COND_AUTO_REPEAT_EN
            if (lvl_now) model_fire();
            else m_busy = 0;
`else
            m_busy = 0;
`endif
        end

        // Level follows the input once the last DC synchronised samples all disagree with it.
        m_level_q = m_level;
        hist.push_back(s);
        if (hist.size() > DC) void'(hist.pop_front());
        if (hist.size() == DC) begin
            differ = 1;
            foreach (hist[i]) if (hist[i] == m_level) differ = 0;
            if (differ) begin
                m_level = s;
                hist.delete();
            end
        end

        m_s2 = m_s1;
        m_s1 = button_in;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!reset) model_step();
    end

    // Monitor: per-cycle output compare plus scoreboard pop on each trigger rise.
    logic trig_prev = 1'b0;
    int   rise_count = 0;

    always @(negedge clk) begin
        trig_ev_t ev;
        check("trigger", 32'(trigger), 32'(m_trig));
        check("busy", 32'(busy), 32'(m_busy));
        check("overrun", 32'(overrun), 32'(m_over));
        check("delay_value", 32'(delay_value), 32'(m_delay));
        if (trigger === 1'b1 && trig_prev !== 1'b1) begin
            rise_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_trigger: got trigger rise expected none (cycle %0d)", cyc);
            end else begin
                ev = exp_q.pop_front();
                check("trig_delay", 32'(delay_value), 32'(ev.delay));
                check("trig_cycle", 32'(cyc), ev.cyc);
            end
        end
        trig_prev = trigger;
    end

    // Downstream timer stand-in: drops done after a trigger, raises it a few clocks later.
    bit   timer_hold = 0;
    int   pend_lo = -1;
    int   pend_hi = -1;
    logic tprev = 1'b0;

    always @(negedge clk) begin
        if (trigger === 1'b1 && tprev !== 1'b1) begin
            pend_lo = $urandom_range(0, 3);
            pend_hi = -1;
        end
        tprev = trigger;
        if (pend_lo > 0) pend_lo--;
        else if (pend_lo == 0) begin
            timer_done = 1'b0;
            pend_lo    = -1;
            pend_hi    = $urandom_range(1, 6);
        end else if (pend_hi > 0) pend_hi--;
        else if (pend_hi == 0 && !timer_hold) begin
            timer_done = 1'b1;
            pend_hi    = -1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL %s: got busy=%b expected 0 within %0d cycles", name, busy, budget);
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #2 reset = 1'b1;
        model_clear();
        #1;
        check("rst_trigger", 32'(trigger), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_delay", 32'(delay_value), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    initial begin
        int rc0;
        int run;
        model_clear();

        repeat (3) @(negedge clk);
        check("reset_trigger", 32'(trigger), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_delay", 32'(delay_value), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        #2 reset = 1'b0;
        tick(2);

        // Clean press: trigger high after edges DC+3 and DC+4 only.
        @(negedge clk);
        button_in = 1'b1;
        delay_sel = 8'h10;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 6) check("lat_pre", 32'(trigger), 32'd0);
            if (k == 7) begin
                check("lat_first", 32'(trigger), 32'd1);
                check("lat_delay", 32'(delay_value), 32'h10);
                check("lat_busy", 32'(busy), 32'd1);
            end
            if (k == 8) check("lat_second", 32'(trigger), 32'd1);
            if (k == 9) check("lat_drop", 32'(trigger), 32'd0);
        end

        // Held through completion; new delay_sel only matters for auto repeat.
        delay_sel = 8'h20;
        rc0 = rise_count;
        tick(40);
`ifndef TRIGGER_COND_AUTO_REPEAT_EN
        check("held_no_retrigger", 32'(rise_count - rc0), 32'd0);
        check("held_idle", 32'(busy), 32'd0);
`endif
        button_in = 1'b0;
        tick(10);
        wait_idle(100, "idle_after_release");

        // Glitch shorter than the debounce window.
        rc0 = rise_count;
        button_in = 1'b1;
        tick(3);
        button_in = 1'b0;
        tick(15);
        check("glitch_no_trigger", 32'(rise_count - rc0), 32'd0);
        check("glitch_busy", 32'(busy), 32'd0);

        // Overrun: second press while the timer is still running.
        timer_hold = 1;
        delay_sel  = 8'h33;
        button_in  = 1'b1;
        tick(10);
        button_in = 1'b0;
        tick(8);
        rc0 = rise_count;
        button_in = 1'b1;
        tick(10);
        check("overrun_set", 32'(overrun), 32'd1);
        check("overrun_no_trigger", 32'(rise_count - rc0), 32'd0);
        button_in   = 1'b0;
        overrun_clr = 1'b1;
        tick(1);
        overrun_clr = 1'b0;
        tick(1);
        check("overrun_cleared", 32'(overrun), 32'd0);
        timer_hold = 0;
        tick(10);
        wait_idle(100, "idle_after_overrun");

        // Asynchronous reset while the trigger is high.
        button_in = 1'b1;
        delay_sel = 8'h5a;
        run = 0;
        while (trigger !== 1'b1 && run < 30) begin
            @(negedge clk);
            run++;
        end
        check("fire_reached", 32'(trigger), 32'd1);
        #2 reset = 1'b1;
        model_clear();
        #1;
        check("async_trigger", 32'(trigger), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_delay", 32'(delay_value), 32'd0);
        button_in = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        rc0 = rise_count;
        tick(20);
        check("post_reset_quiet", 32'(rise_count - rc0), 32'd0);

        // Random traffic.
        run = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (run == 0) begin
                button_in = 1'($urandom_range(0, 1));
                run = $urandom_range(1, 12);
            end else begin
                run--;
            end
            delay_sel   = DW'($urandom);
            overrun_clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 599) == 0) reset_pulse();
        end

        button_in   = 1'b0;
        overrun_clr = 1'b0;
        tick(20);
        wait_idle(200, "final_idle");
        tick(5);
        check("pending_triggers", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trigger_conditioner.md
Name: trigger_conditioner

Overview:
Upstream front-end for the delay timer. Synchronises and debounces a raw pushbutton or external event and latches the requested delay. It then issues a clean trigger pulse plus delay value to the timer and locks out new events until the timer reports completion on its delayed output. Overruns (events arriving while busy) are flagged.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples required to accept a level change (>=1)
CNT_W, 5, debounce counter width; must hold DEBOUNCE_CYCLES-1
TRIG_CYCLES, 1, trigger pulse length in clocks (>=1)
DELAY_W, 8, delay value width

Ports:
clk  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-high; all state cleared immediately
button_in  in  1  raw asynchronous event input, active-high
delay_sel  in  DELAY_W  requested delay; sampled on accepted event
timer_done  in  1  delayed output from the downstream delay timer
overrun_clr  in  1  synchronous clear of overrun flag
trigger  out  1  registered trigger pulse to the timer
delay_value  out  DELAY_W  registered delay to the timer; stable from trigger rise until the next accepted event
busy  out  1  high in FIRE, WAIT_LO and WAIT_HI
overrun  out  1  sticky: event rise seen while busy

Behaviour:
- Reset values: trigger=0, delay_value=0, busy=0, overrun=0, state=IDLE, sync flops=0, debounced level=0, counter=0.
- Sync: 2-flop synchroniser on button_in gives S.
- Debounce:
  - counter clears whenever S==level.
  - When S!=level, counter increments.
  - When counter==DEBOUNCE_CYCLES-1 and S!=level: level<=S and counter<=0.
  - A level change therefore needs DEBOUNCE_CYCLES consecutive differing samples.
- Edge: rise = level & ~level_q (level_q is level delayed one clock).
- FSM states: IDLE, FIRE, WAIT_LO, WAIT_HI.
  - IDLE: on rise -> FIRE; delay_value<=delay_sel; trigger<=1.
  - FIRE: hold trigger high for exactly TRIG_CYCLES clocks, then trigger<=0 and -> WAIT_LO.
  - WAIT_LO: wait for timer_done==0, then -> WAIT_HI. This guards against a stale high from the previous run.
  - WAIT_HI: on timer_done==1 -> IDLE.
- Latency: button_in rising before clock edge 1 and held → trigger first high after edge DEBOUNCE_CYCLES+3.
- Lockout: a rise in FIRE, WAIT_LO or WAIT_HI is ignored for triggering and sets overrun.
- Overrun flag: overrun_clr clears it. If a rise and overrun_clr occur in the same cycle, the set wins.
- Glitches: a pulse shorter than DEBOUNCE_CYCLES synchronised samples produces no level change and no trigger.
- delay_sel=0 is legal. The timer returns timer_done high shortly after the trigger drops, and the FSM handles this via WAIT_LO/WAIT_HI.
- Button held through reset: level restarts at 0, so a held-high input produces exactly one trigger after release of reset plus debounce.
- Reset mid-operation: trigger drops asynchronously and the FSM returns to IDLE; no trigger is generated on reset release unless a new debounced rise occurs.

Optional Feature:
TRIGGER_COND_AUTO_REPEAT_EN
- Defined: in WAIT_HI, if timer_done==1 and level==1 (button still held), go directly to FIRE. delay_sel is re-sampled and trigger is reissued, giving periodic retriggering. This path does not set overrun.
- Undefined: WAIT_HI always returns to IDLE, and a fresh debounced rise (release then press) is required.

Decomposition:
- Package trigger_cond_pkg: FSM state enum (IDLE, FIRE, WAIT_LO, WAIT_HI) and default width constants DELAY_W_DEF=8, CNT_W_DEF=5.
- Sub-module trig_debounce: synchroniser plus debounce counter.
  - Parameters DEBOUNCE_CYCLES, CNT_W.
  - Ports clk, reset, raw_in, level_out.
- Top-level: edge detect, FSM, delay latch, overrun logic.

Test Plan (DEBOUNCE_CYCLES=4, TRIG_CYCLES=2):
- Clean press: button_in=1 held, delay_sel=8'h10 → trigger high after edges 7 and 8 only; delay_value=8'h10; busy=1.
- Completion: model timer_done low then high 5 clocks later → busy falls the edge after timer_done rises; state=IDLE; no second trigger while the button is held (macro undefined).
- Glitch: button_in high for 3 synchronised samples, then low → no trigger, busy stays 0.
- Overrun: second clean press during WAIT_HI → no trigger, overrun=1. Then assert overrun_clr for one clock → overrun=0.
- Async reset during FIRE: reset pulse mid-trigger → trigger, busy, delay_value go to 0 before the next clock edge; nothing fires after reset drops with the button low.
- AUTO_REPEAT (macro defined): button held, timer_done returns high → trigger reissued 2 clocks long with the newly sampled delay_sel=8'h20.
